order_link_rx: RTL
==================

# order_link_rx

Serial receiver for the order link between boards: the far end of the ping/enable serial protocol driven by the user board's order transmitter. Deserializes one 32-bit order per frame from `data_ping_in`/`comEn` into a single-entry output buffer with a valid/ready handshake toward the exchange-side logic. Detects truncated, over-long and dropped frames and flags them.

## Interface
- `WIDTH`, 32: order width in bits; equals bits per frame.
- `BIT_CYCLES`, 8: `clock` cycles per serial bit; must be even and ≥ 4.
- `END_TIMEOUT`, 2*BIT_CYCLES: cycles `comEn` may stay high after the last bit.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `data_ping_in`  in  1  serial data, MSB first, asynchronous to `clock`.
- `comEn`  in  1  frame enable; high for the whole frame, asynchronous.
- `order`  out  WIDTH  received order; stable while `order_valid` is high.
- `order_valid`  out  1  buffer holds an unconsumed order.
- `order_ready`  in  1  consumer accepts `order` when high together with `order_valid`.
- `frame_error`  out  1  one-cycle pulse: truncated or over-long frame.
- `overrun`  out  1  one-cycle pulse: complete frame dropped because buffer full.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Both inputs pass through 2-flop synchronizers (`en_s`, `data_s`); `en_d` is `en_s` delayed one cycle; start = `en_s & ~en_d`.
- Bit sample counter `cnt` (log2 BIT_CYCLES bits), bit counter `nbits` (log2 WIDTH + 1 bits), shift register `shreg` (shift left, new bit into LSB).
- IDLE: on start → ALIGN, `cnt`=0, `nbits`=0.
- ALIGN: `cnt` counts to BIT_CYCLES/2−1; on that cycle sample `data_s`, `nbits`=1, `cnt`=0 → SAMPLE.
- SAMPLE: when `cnt`==BIT_CYCLES−1 sample, `nbits`+1, `cnt`=0; the sample making `nbits`==WIDTH → WAIT_END.
- ALIGN or SAMPLE with `en_s` low: `frame_error` pulse, discard `shreg`, → IDLE.
- WAIT_END: `en_s` low → deliver, → IDLE. `en_s` still high after END_TIMEOUT cycles → `frame_error` pulse, → DRAIN.
- DRAIN: wait for `en_s` low, no delivery, → IDLE.
- Deliver: if `order_valid`==0 or `order_ready`==1 this cycle, `order`←`shreg`, `order_valid`=1; else `overrun` pulse, frame dropped, `order` unchanged.
- Handshake: transfer when `order_valid & order_ready`; `order_valid` clears next cycle unless a delivery reloads it in the same cycle.
- A start seen in any non-IDLE state is ignored.

## Timing
- Reset values: `order`=0, `order_valid`=0, `frame_error`=0, `overrun`=0, `busy`=0; state IDLE; synchronizers cleared. Reset mid-frame abandons the frame with no pulse.
- Input-to-start detect: 3 cycles (2 sync + edge register).
- First bit sampled BIT_CYCLES/2 cycles after start detect (mid-bit); subsequent bits every BIT_CYCLES.
- `order_valid` rises the cycle after WAIT_END sees `en_s` low.
- `frame_error`/`overrun` are exactly one cycle wide; never both in the same cycle.
- Minimum frame gap accepted: 1 synchronized low cycle of `comEn`.

## Structure
- Shared package `order_link_pkg`: state encoding (IDLE, ALIGN, SAMPLE, WAIT_END, DRAIN), default WIDTH, default BIT_CYCLES; shared with the transmitter so both ends agree on frame format.
- One sub-module: `sync2` (2-flop synchronizer), instantiated twice.

## Test plan
- BIT_CYCLES=8, frame 0xDEADBEEF, `order_ready`=1 → `order`=0xDEADBEEF, `order_valid` high one cycle, no error pulses.
- `comEn` dropped after 10 bits → one `frame_error` pulse, `order_valid` stays 0, `busy` falls.
- Frames 0x00000001 then 0xFFFFFFFF with `order_ready`=0 → `order`=0x00000001 held, one `overrun` pulse on second frame.
- Full frame then `comEn` held high 20 extra cycles → `frame_error`, no delivery; next frame 0x12345678 received correctly.
- `reset` asserted after bit 16 → all outputs 0 next cycle; following frame 0xA5A5A5A5 received correctly.
- Back-to-back frames 0x11111111, 0x22222222 with 1-cycle gap, `order_ready` high → both delivered in order, no errors.

Source files
------------

// File: rtl/order_link_pkg.sv
// Frame-format definitions shared by both ends of the order link.
package order_link_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_BIT_CYCLES = 8;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      SAMPLE,
      WAIT_END,
      DRAIN
   } link_state_t;

endpackage

// File: rtl/order_link_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous control or data line.
module sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Resample the asynchronous input twice before anything else looks at it.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so meta and q
      // update together; blocking here would collapse the chain to one flop.
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/order_link_rx.sv
// Receiving end of the order link: deserializes one order per comEn frame
// into a single-entry buffer with a valid/ready handshake.
module order_link_rx
   import order_link_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int BIT_CYCLES  = DEF_BIT_CYCLES,
   parameter int END_TIMEOUT = 2 * BIT_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             data_ping_in,
   input  logic             comEn,
   output logic [WIDTH-1:0] order,
   output logic             order_valid,
   input  logic             order_ready,
   output logic             frame_error,
   output logic             overrun,
   output logic             busy
);

   localparam int CNT_W = $clog2(BIT_CYCLES);
   localparam int NB_W  = $clog2(WIDTH) + 1;
   localparam int TO_W  = $clog2(END_TIMEOUT + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [NB_W-1:0]  NB_LAST   = NB_W'(WIDTH - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(END_TIMEOUT - 1);

   logic             en_s;
   logic             data_s;
   logic             en_d;
   logic             start;
   link_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [NB_W-1:0]  nbits;
   logic [TO_W-1:0]  tcnt;
   logic [WIDTH-1:0] shreg;

   sync2 u_sync_en (
      .clock (clock),
      .reset (reset),
      .d     (comEn),
      .q     (en_s)
   );

   sync2 u_sync_data (
      .clock (clock),
      .reset (reset),
      .d     (data_ping_in),
      .q     (data_s)
   );

   // Delay the synchronized enable by one cycle for rising-edge detection.
   always_ff @(posedge clock) begin
      if (reset) en_d <= 1'b0;
      else       en_d <= en_s;
   end

   assign start = en_s & ~en_d;

   // Frame FSM with registered buffer, handshake and status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         nbits       <= '0;
         tcnt        <= '0;
         shreg       <= '0;
         order       <= '0;
         order_valid <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         // Status pulses default low so each assertion lasts one cycle.
         frame_error <= 1'b0;
         overrun     <= 1'b0;

         // Consumer took the order; a delivery below may reload it.
         if (order_valid && order_ready) order_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state <= ALIGN;
                  cnt   <= '0;
                  nbits <= '0;
                  busy  <= 1'b1;
               end
            end

            ALIGN: begin
               if (!en_s) begin
                  frame_error <= 1'b1;
                  state       <= IDLE;
                  busy        <= 1'b0;
               end else if (cnt == HALF_LAST) begin
                  shreg <= {shreg[WIDTH-2:0], data_s};
                  nbits <= NB_W'(1);
                  cnt   <= '0;
                  state <= SAMPLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            SAMPLE: begin
               if (!en_s) begin
                  frame_error <= 1'b1;
                  state       <= IDLE;
                  busy        <= 1'b0;
               end else if (cnt == BIT_LAST) begin
                  shreg <= {shreg[WIDTH-2:0], data_s};
                  nbits <= nbits + 1'b1;
                  cnt   <= '0;
                  if (nbits == NB_LAST) begin
                     state <= WAIT_END;
                     tcnt  <= '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            WAIT_END: begin
               if (!en_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (!order_valid || order_ready) begin
                     order       <= shreg;
                     order_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else if (tcnt == TO_LAST) begin
                  frame_error <= 1'b1;
                  state       <= DRAIN;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            DRAIN: begin
               if (!en_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
